// File: rtl/led_scan_ctrl.sv
// Multiplexed LED line scanner: walks a LINES x COLS frame buffer out to a two-register LED port.
// Define LED_SCAN_DBUF_EN for front/back double buffering with frame-synchronous swaps.
module led_scan_ctrl #(
    parameter int LINES   = 20,
    parameter int COLS    = 10,
    parameter int DWELL_W = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [4:0]         iFbAddr,
    input  logic [COLS-1:0]    iFbData,
    input  logic               iFbWEnb,
    input  logic               iEnable,
    input  logic [DWELL_W-1:0] iDwell,
    input  logic               iSwap,
    output logic [3:0]         oAddr,
    output logic [15:0]        oData,
    output logic               oWEnb,
    output logic               oFrameTick
);

    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_LINE, DWELL, BLANK_D, BLANK_L} stateT;

    stateT              state;
    logic [LINE_W-1:0]  line;
    logic [LINE_W-1:0]  stepLine;
    logic [LINE_W-1:0]  readLine;
    logic [DWELL_W-1:0] dwellCnt;
    logic [DWELL_W-1:0] dwellLoad;
    logic               lastLine;
    logic               dwellDone;
    logic               wrapEdge;
    logic               fbWrite;
    logic [COLS-1:0]    readData;

    assign lastLine  = (line == LINE_W'(LINES - 1));
    assign stepLine  = lastLine ? '0 : line + 1'b1;
    assign dwellDone = (state == DWELL) && (dwellCnt <= DWELL_W'(1));
    assign wrapEdge  = dwellDone && iEnable && lastLine;
    assign dwellLoad = (iDwell == '0) ? DWELL_W'(1) : iDwell;
    assign fbWrite   = iFbWEnb && (int'(iFbAddr) < LINES);

    // The buffer is read on the edge that enters WR_DATA, so the line fetched is the one being moved to.
    assign readLine  = (state == DWELL) ? stepLine : '0;

`ifdef LED_SCAN_DBUF_EN
    logic [COLS-1:0] fb [2][LINES];
    logic            frontSel;
    logic            swapPending;
    logic            doSwap;
    logic            readSel;

    assign doSwap   = (swapPending || iSwap) && (wrapEdge || state == IDLE);
    assign readSel  = doSwap ? ~frontSel : frontSel;
    assign readData = fb[readSel][readLine];

    // CPU always fills the back buffer; contents survive reset on purpose.
    always_ff @(posedge iClk) begin
        if (fbWrite) begin
            fb[~frontSel][iFbAddr[LINE_W-1:0]] <= iFbData;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            frontSel    <= 1'b0;
            swapPending <= 1'b0;
        end else if (doSwap) begin
            frontSel    <= ~frontSel;
            swapPending <= 1'b0;
        end else if (iSwap) begin
            swapPending <= 1'b1;
        end
    end
`else
    logic [COLS-1:0] fb [LINES];
    logic            unusedSwap;

    assign unusedSwap = iSwap;
    assign readData   = fb[readLine];

    always_ff @(posedge iClk) begin
        if (fbWrite) begin
            fb[iFbAddr[LINE_W-1:0]] <= iFbData;
        end
    end
`endif

    // Outputs are loaded on the edge entering each state, so they are valid for that state's whole cycle.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= IDLE;
            line       <= '0;
            dwellCnt   <= '0;
            oAddr      <= 4'd0;
            oData      <= 16'd0;
            oWEnb      <= 1'b0;
            oFrameTick <= 1'b0;
        end else begin
            oFrameTick <= 1'b0;
            case (state)
                IDLE: begin
                    line  <= '0;
                    oWEnb <= 1'b0;
                    oAddr <= 4'd0;
                    oData <= 16'd0;
                    if (iEnable) begin
                        state <= WR_DATA;
                        oWEnb <= 1'b1;
                        oData <= 16'(readData);
                    end
                end
                WR_DATA: begin
                    state <= WR_LINE;
                    oWEnb <= 1'b1;
                    oAddr <= 4'd1;
                    oData <= 16'(line);
                end
                WR_LINE: begin
                    state    <= DWELL;
                    dwellCnt <= dwellLoad;
                    oWEnb    <= 1'b0;
                    oAddr    <= 4'd0;
                    oData    <= 16'd0;
                end
                DWELL: begin
                    dwellCnt <= dwellCnt - 1'b1;
                    if (dwellDone) begin
                        oWEnb <= 1'b1;
                        oAddr <= 4'd0;
                        if (iEnable) begin
                            state      <= WR_DATA;
                            line       <= stepLine;
                            oData      <= 16'(readData);
                            oFrameTick <= wrapEdge;
                        end else begin
                            state <= BLANK_D;
                            oData <= 16'd0;
                        end
                    end
                end
                BLANK_D: begin
                    state <= BLANK_L;
                    oWEnb <= 1'b1;
                    oAddr <= 4'd1;
                    oData <= 16'(line);
                end
                BLANK_L: begin
                    state <= IDLE;
                    line  <= '0;
                    oWEnb <= 1'b0;
                    oAddr <= 4'd0;
                    oData <= 16'd0;
                end
                default: begin
                    state <= IDLE;
                    line  <= '0;
                    oWEnb <= 1'b0;
                    oAddr <= 4'd0;
                    oData <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: a line-position model checked every cycle, plus hand-computed literal pins.
// Build with LED_SCAN_DBUF_EN defined to exercise the double-buffered variant.
module tb_led_scan_ctrl;

    localparam int LINES   = 20;
    localparam int COLS    = 10;
    localparam int DWELL_W = 16;
`ifdef LED_SCAN_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic               iClk = 1'b0;
    logic               iRst = 1'b0;
    logic [4:0]         iFbAddr = '0;
    logic [COLS-1:0]    iFbData = '0;
    logic               iFbWEnb = 1'b0;
    logic               iEnable = 1'b0;
    logic [DWELL_W-1:0] iDwell = '0;
    logic               iSwap = 1'b0;
    logic [3:0]         oAddr;
    logic [15:0]        oData;
    logic               oWEnb;
    logic               oFrameTick;

    int errors = 0;
    int checks = 0;

    led_scan_ctrl #(.LINES(LINES), .COLS(COLS), .DWELL_W(DWELL_W)) dut (
        .iClk(iClk), .iRst(iRst), .iFbAddr(iFbAddr), .iFbData(iFbData), .iFbWEnb(iFbWEnb),
        .iEnable(iEnable), .iDwell(iDwell), .iSwap(iSwap),
        .oAddr(oAddr), .oData(oData), .oWEnb(oWEnb), .oFrameTick(oFrameTick)
    );

    always #5 iClk = ~iClk;

    function automatic logic [9:0] pat(input int i);
        if (i == 0) return 10'h155;
        if (i == 19) return 10'h2AA;
        return 10'(i * 37 + 5);
    endfunction

    // Model: tracks the position inside the current line period rather than any state encoding.
    // mMode 0 = idle, 1 = scanning, 2 = blank data write, 3 = blank line write.
    int          mMode = 0;
    int          mLine = 0;
    int          mPos = 0;
    int          mPeriod = 3;
    int          mFront = 0;
    bit          mPend = 1'b0;
    logic [9:0]  mFb [2][LINES];
    logic        eWen = 1'b0;
    logic        eTick = 1'b0;
    logic [3:0]  eAddr = '0;
    logic [15:0] eData = '0;

    always @(posedge iClk or negedge iRst) begin : model
        int oldFront;
        bit swapReq;
        bit swapped;
        if (!iRst) begin
            mMode = 0; mLine = 0; mPos = 0; mFront = 0; mPend = 1'b0;
            eWen = 1'b0; eTick = 1'b0; eAddr = '0; eData = '0;
        end else begin
            oldFront = mFront;
            swapReq  = DBUF && (mPend || iSwap);
            swapped  = 1'b0;
            eWen = 1'b0; eTick = 1'b0; eAddr = '0; eData = '0;
            case (mMode)
                0: begin
                    if (swapReq) begin mFront = 1 - mFront; swapped = 1'b1; end
                    if (iEnable) begin
                        mMode = 1; mLine = 0; mPos = 0;
                        eWen = 1'b1; eData = 16'(mFb[mFront][0]);
                    end
                end
                1: begin
                    if (mPos == 0) begin
                        eWen = 1'b1; eAddr = 4'd1; eData = 16'(mLine); mPos = 1;
                    end else if (mPos == 1) begin
                        mPeriod = 2 + ((iDwell == 0) ? 1 : int'(iDwell));
                        mPos = 2;
                    end else if (mPos == mPeriod - 1) begin
                        eWen = 1'b1;
                        if (iEnable) begin
                            mLine = (mLine + 1) % LINES;
                            if (mLine == 0) begin
                                eTick = 1'b1;
                                if (swapReq) begin mFront = 1 - mFront; swapped = 1'b1; end
                            end
                            mPos = 0;
                            eData = 16'(mFb[mFront][mLine]);
                        end else begin
                            mMode = 2;
                        end
                    end else begin
                        mPos = mPos + 1;
                    end
                end
                2: begin
                    eWen = 1'b1; eAddr = 4'd1; eData = 16'(mLine); mMode = 3;
                end
                default: begin
                    mMode = 0; mLine = 0;
                end
            endcase
            if (swapped) mPend = 1'b0;
            else if (DBUF && iSwap) mPend = 1'b1;
            if (iFbWEnb && int'(iFbAddr) < LINES)
                mFb[DBUF ? 1 - oldFront : 0][iFbAddr] = iFbData;
        end
    end

    // Every cycle: strobe and frame tick always, address/data whenever a port write is expected.
    always @(negedge iClk) begin
        checks++;
        if (oWEnb !== eWen) begin
            errors++;
            $display("[TB] FAIL model oWEnb @%0t: got %b want %b", $time, oWEnb, eWen);
        end
        checks++;
        if (oFrameTick !== eTick) begin
            errors++;
            $display("[TB] FAIL model oFrameTick @%0t: got %b want %b", $time, oFrameTick, eTick);
        end
        if (eWen) begin
            checks++;
            if ({oAddr, oData} !== {eAddr, eData}) begin
                errors++;
                $display("[TB] FAIL model addr/data @%0t: got (%0h,%h) want (%0h,%h)",
                         $time, oAddr, oData, eAddr, eData);
            end
        end
    end

    task automatic stepClk(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [9:0] data,
                                 input logic swap);
        iFbWEnb = we;
        iFbAddr = addr;
        iFbData = data;
        iSwap   = swap;
    endtask

    task automatic checkOutput(input string name, input logic wen, input logic [3:0] addr,
                               input logic [15:0] data);
        checks++;
        if (oWEnb !== wen || (wen && {oAddr, oData} !== {addr, data})) begin
            errors++;
            $display("[TB] FAIL %s: got wen=%b (%0h,%h) want wen=%b (%0h,%h)",
                     name, oWEnb, oAddr, oData, wen, addr, data);
        end
    endtask

    task automatic checkTick(input string name, input logic tick);
        checks++;
        if (oFrameTick !== tick) begin
            errors++;
            $display("[TB] FAIL %s: got tick=%b want tick=%b", name, oFrameTick, tick);
        end
    endtask

    task automatic checkAllZero(input string name);
        checks++;
        if ({oWEnb, oFrameTick, oAddr, oData} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL %s: got wen=%b tick=%b addr=%0h data=%h want all zero",
                     name, oWEnb, oFrameTick, oAddr, oData);
        end
    endtask

    task automatic waitLine(input int ln);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            stepClk(1);
            if (oWEnb === 1'b1 && oAddr === 4'd1 && oData === 16'(ln)) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("[TB] FAIL waitLine %0d: got no line write want one within 300 cycles", ln);
        end
    endtask

    task automatic waitWrData();
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            stepClk(1);
            if (oWEnb === 1'b1 && oAddr === 4'd0) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("[TB] FAIL waitWrData: got no data write want one within 300 cycles");
        end
    endtask

    task automatic fillBuffer();
        for (int i = 0; i < LINES; i++) begin
            applyStimulus(1'b1, 5'(i), pat(i), 1'b0);
            stepClk(1);
        end
        applyStimulus(1'b1, 5'd23, 10'h0F0, 1'b0);
        stepClk(1);
        applyStimulus(1'b0, 5'd0, 10'h000, 1'b0);
    endtask

    initial begin
        #1;
        checkAllZero("reset outputs");
        stepClk(2);
        iRst = 1'b1;

        fillBuffer();
        if (DBUF) begin
            applyStimulus(1'b0, 5'd0, 10'h000, 1'b1);
            stepClk(1);
            applyStimulus(1'b0, 5'd0, 10'h000, 1'b0);
            fillBuffer();
        end
        stepClk(1);

        // Basic scan with a three-cycle dwell: five-cycle lines, hundred-cycle frames.
        iDwell = 16'd3;
        iEnable = 1'b1;
        stepClk(1);  checkOutput("line0 data", 1'b1, 4'd0, 16'h0155);
        checkTick("no tick at first line", 1'b0);
        stepClk(1);  checkOutput("line0 select", 1'b1, 4'd1, 16'h0000);
        stepClk(1);  checkOutput("dwell 1", 1'b0, 4'd0, 16'h0000);
        stepClk(1);  checkOutput("dwell 2", 1'b0, 4'd0, 16'h0000);
        stepClk(1);  checkOutput("dwell 3", 1'b0, 4'd0, 16'h0000);
        stepClk(1);  checkOutput("line1 data", 1'b1, 4'd0, 16'h002A);
        stepClk(90); checkOutput("line19 data", 1'b1, 4'd0, 16'h02AA);
        stepClk(1);  checkOutput("line19 select", 1'b1, 4'd1, 16'h0013);
        stepClk(4);  checkOutput("wrap line0 data", 1'b1, 4'd0, 16'h0155);
        checkTick("frame tick 1", 1'b1);
        stepClk(99); checkTick("no tick before frame end", 1'b0);
        stepClk(1);  checkTick("frame tick 2", 1'b1);

        // Zero dwell behaves like one: three-cycle line period.
        iDwell = 16'd0;
        stepClk(3);  checkOutput("dwell0 line1 data", 1'b1, 4'd0, 16'h002A);
        stepClk(3);  checkOutput("dwell0 line2 data", 1'b1, 4'd0, 16'h004F);

        // Mid-frame write to line 2 plus a swap request.
        waitLine(1);
        applyStimulus(1'b1, 5'd2, 10'h3FF, 1'b1);
        stepClk(1);
        applyStimulus(1'b0, 5'd0, 10'h000, 1'b0);
        waitWrData();
        checkOutput("line2 after write, same frame", 1'b1, 4'd0,
                    DBUF ? 16'h004F : 16'h03FF);
        waitLine(19);
        waitWrData();
        checkTick("tick after swap request", 1'b1);
        waitWrData();
        waitWrData();
        checkOutput("line2 next frame", 1'b1, 4'd0, 16'h03FF);

        // Concurrent CPU writes, dwell changes, a short enable glitch and a swap.
        for (int c = 0; c < 60; c++) begin
            applyStimulus(1'b1, 5'((c * 7) % 24), 10'(c * 13 + 1), c == 30);
            iDwell  = (c < 20) ? 16'd2 : 16'd1;
            iEnable = !(c >= 40 && c < 43);
            stepClk(1);
        end
        applyStimulus(1'b0, 5'd0, 10'h000, 1'b0);
        iEnable = 1'b1;

        // Disable during line 5 dwell: dwell finishes, blank, then idle.
        iDwell = 16'd3;
        waitLine(5);
        stepClk(1);
        iEnable = 1'b0;
        stepClk(3);  checkOutput("blank data", 1'b1, 4'd0, 16'h0000);
        stepClk(1);  checkOutput("blank line5", 1'b1, 4'd1, 16'h0005);
        stepClk(1);  checkOutput("idle after blank", 1'b0, 4'd0, 16'h0000);
        stepClk(10); checkOutput("stays idle", 1'b0, 4'd0, 16'h0000);

        // Reset in the middle of line 7 dwell.
        iEnable = 1'b1;
        waitLine(7);
        stepClk(1);
        #1 iRst = 1'b0;
        #1 checkAllZero("async reset mid dwell");
        stepClk(2);
        iRst = 1'b1;
        stepClk(2);  checkOutput("restart at line0", 1'b1, 4'd1, 16'h0000);

        stepClk(150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 20, number of scan lines.
REQ-002 SHALL have parameter COLS, default 10, LED columns per line.
REQ-003 SHALL have parameter DWELL_W, default 16, width of the dwell counter and iDwell.
REQ-004 SHALL have port iClk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port iRst  input  1  asynchronous, active-low reset; state clears immediately when low.
REQ-006 SHALL have port iFbAddr  input  5  frame-buffer line index written by the CPU.
REQ-007 SHALL have port iFbData  input  COLS  frame-buffer line data.
REQ-008 SHALL have port iFbWEnb  input  1  frame-buffer write strobe.
REQ-009 SHALL have port iEnable  input  1  scan enable.
REQ-010 SHALL have port iDwell  input  DWELL_W  clock cycles each line stays lit.
REQ-011 SHALL have port iSwap  input  1  buffer swap request; used only when LED_SCAN_DBUF_EN is defined.
REQ-012 SHALL have port oAddr  output  4  LED port address: 0 = LEDData, 1 = LEDLine.
REQ-013 SHALL have port oData  output  16  LED port write data.
REQ-014 SHALL have port oWEnb  output  1  LED port write strobe.
REQ-015 SHALL have port oFrameTick  output  1  one-cycle pulse at the end of each frame.

Function
REQ-016 SHALL hold a LINES x COLS frame buffer; a write with iFbWEnb=1 and iFbAddr<LINES stores iFbData on the clock edge; iFbAddr>=LINES is ignored.
REQ-017 SHALL implement FSM states IDLE, WR_DATA, WR_LINE, DWELL, BLANK_D, BLANK_L; all outputs registered.
REQ-018 IDLE: while iEnable=1, go to WR_DATA with line index 0; otherwise stay in IDLE with oWEnb=0.
REQ-019 WR_DATA: one cycle with oWEnb=1, oAddr=0, oData={zero-extended fb[line]}; next state WR_LINE.
REQ-020 WR_LINE: one cycle with oWEnb=1, oAddr=1, oData=line; latch dwell count = max(iDwell,1); next state DWELL.
REQ-021 DWELL: oWEnb=0; decrement the count each cycle; when it reaches 0, leave DWELL.
REQ-022 DWELL exit with iEnable=1: line increments; LINES-1 wraps to 0 with oFrameTick=1 for one cycle; next state WR_DATA.
REQ-023 DWELL exit with iEnable=0: go to BLANK_D.
REQ-024 BLANK_D: one cycle with oWEnb=1, oAddr=0, oData=0; next state BLANK_L.
REQ-025 BLANK_L: one cycle with oWEnb=1, oAddr=1, oData=line, which latches blank data downstream; next state IDLE with line reset to 0.
REQ-026 The line period SHALL be exactly 2+max(iDwell,1) cycles; the frame period SHALL be LINES times that.
REQ-027 WR_DATA SHALL read buffer content as of the previous edge; a same-cycle write to the same line SHALL appear on that line's next scan.
REQ-028 iEnable deasserted outside DWELL SHALL take effect only at the next DWELL exit; the scan never stops mid-write.
REQ-029 iDwell changes SHALL take effect only at the next WR_LINE.

Reset
REQ-030 When iRst=0, SHALL asynchronously set state=IDLE, line=0, dwell count=0, oAddr=0, oData=0, oWEnb=0, oFrameTick=0.
REQ-031 Reset SHALL NOT clear frame-buffer contents; after reset they are undefined until written.
REQ-032 Reset in mid-frame SHALL abort the scan; after release the next scan starts at line 0.

Configuration
REQ-033 With LED_SCAN_DBUF_EN defined, SHALL provide two buffers (front and back); CPU writes go to back; WR_DATA reads front.
REQ-034 With LED_SCAN_DBUF_EN: an iSwap pulse SHALL set a pending flag; the buffers swap in the cycle oFrameTick=1, or immediately when in IDLE; the flag then clears.
REQ-035 Without LED_SCAN_DBUF_EN: single buffer; CPU writes are visible on the next scan of that line; iSwap is ignored.

Verification
REQ-036 Write fb[0]=0x155, fb[19]=0x2AA, iDwell=3, iEnable=1 -> writes (0,0x155),(1,0); 3 idle cycles; 5-cycle line period; line 19 shows (0,0x2AA).
REQ-037 Run one full frame with iDwell=3 -> oFrameTick pulses every 100 cycles; line sequence 0..19 then wraps to 0.
REQ-038 iDwell=0 -> identical to iDwell=1; 3-cycle line period.
REQ-039 Drop iEnable during line 5 dwell -> dwell completes, then (0,0),(1,5), then IDLE; oWEnb stays 0 afterward.
REQ-040 Pull iRst low mid-DWELL on line 7 -> all outputs 0 at once; after release with iEnable=1, scan restarts at line 0.
REQ-041 With LED_SCAN_DBUF_EN: write back fb[2]=0x3FF, pulse iSwap mid-frame -> old data shown until the frame ends; 0x3FF shown from the next frame.
